jk_bank_arbiter: RTL
====================

// Module: jk_bank_arbiter
// PURPOSE
//  Owns a bank of WIDTH JK flip-flop cells and shares it between two requesters.
//  Each requester submits a JK op code and a bit mask; the block arbitrates round-robin,
//  applies the op to the masked cells and signals completion.
//  Sits between control FSMs and any status/flag register built from JK cells.
// PARAMETERS
//  WIDTH   8   number of JK cells in the bank (1..32)
// PORTS
//  clk     in   1      rising-edge clock, single clock domain
//  rst     in   1      synchronous reset, active-high, highest priority
//  req0    in   1      requester 0 transaction request (level)
//  jk0     in   2      requester 0 op {j,k}
//  mask0   in   WIDTH  requester 0 cell select (1 = apply op)
//  req1    in   1      requester 1 transaction request (level)
//  jk1     in   2      requester 1 op {j,k}
//  mask1   in   WIDTH  requester 1 cell select
//  gnt0    out  1      requester 0 owns the bank (registered)
//  gnt1    out  1      requester 1 owns the bank (registered)
//  done    out  1      one-cycle completion pulse to current grantee (registered)
//  q       out  WIDTH  cell outputs (registered)
//  qb      out  WIDTH  ~q (combinational)
// BEHAVIOUR
//  - Reset: q=0, qb=all 1s, gnt0=gnt1=0, done=0, state=IDLE, rr pointer favours req0.
//  - FSM: IDLE -> APPLY -> DONE -> IDLE. No other states; illegal encodings -> IDLE.
//  - IDLE: sample req0/req1 at edge E0. None: stay. One: grant it. Both: grant the
//    requester NOT granted last (rr). At E0: latch winner's jk/mask, assert its gnt, go APPLY.
//  - APPLY: at E1, for each bit i with mask[i]=1: {j,k}=00 hold, 01 q[i]<=0,
//    10 q[i]<=1, 11 q[i]<=~q[i]; mask[i]=0 bits hold. Assert done, go DONE.
//  - DONE: done=1 for exactly this cycle, q already shows new value. At E2: drop gnt
//    and done, update rr pointer to the served requester, go IDLE.
//  - Latency: request sampled E0 -> q updated E1 -> free E2; max one op per 3 cycles.
//  - Handshake: requester holds req, jk, mask stable until it sees gnt; jk/mask only
//    sampled at E0. Requester drops req in the done cycle; req still high in IDLE
//    is a new transaction. Changes to req/jk/mask during APPLY/DONE are ignored.
//  - gnt0 and gnt1 never high together; gnt high for exactly APPLY+DONE (2 cycles).
//  - mask=0: full 3-cycle transaction runs, q unchanged, done still pulses.
//  - rst in any state (incl. APPLY/DONE): abort, apply reset values next edge; no done.
//  - Cells never change outside APPLY->DONE edge or reset.
// CONFIGURATION
//  JK_BANK_FIXED_PRIO_EN
//    defined: fixed priority, req0 always wins when both request; rr pointer removed.
//    undefined (default): round-robin as above.
// TESTING
//  1 rst=1 for 2 cycles with req0=1 -> q=0x00, qb=0xFF, gnt0=gnt1=done=0.
//  2 req0=1 jk0=10 mask0=0x0F -> gnt0=1 next cycle, q=0x0F with done=1 one cycle
//    later, gnt0=0 after; total 3 cycles.
//  3 from q=0x0F, req1=1 jk1=11 mask1=0xFF -> gnt1, q=0xF0, done pulse.
//  4 q=0xF0, last grant=1; req0 (jk=01,mask=0x30) and req1 (jk=10,mask=0x01) held
//    -> gnt0 first q=0xC0, then gnt1 q=0xC1; with both held, grants alternate 0,1,0,1.
//  5 req0 jk0=10 mask0=0xFF, rst=1 during APPLY -> q=0x00, gnt0=0, done never pulses.
//  6 JK_BANK_FIXED_PRIO_EN defined, req0 and req1 held high -> gnt0 every transaction,
//    gnt1 never asserted.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// ---------------------------------------------------------------------------
// jk_bank_arbiter
//   Bank of WIDTH JK flip-flop cells shared between two requesters. A request
//   is arbitrated in IDLE, the winner's {j,k} op and cell mask are latched,
//   the op is applied to the masked cells one cycle later, and a one-cycle
//   done pulse closes the transaction. One op at most every 3 cycles.
//
//   Configuration macro: JK_BANK_FIXED_PRIO_EN
//     defined   : requester 0 always wins a tie (no round-robin pointer)
//     undefined : round-robin, the requester not served last wins a tie
//
// Ports
//   i_clk            rising-edge clock
//   i_rst            synchronous reset, active high, highest priority
//   i_req0/i_req1    transaction request level per requester
//   i_jk0/i_jk1      op {j,k}: 00 hold, 01 clear, 10 set, 11 toggle
//   i_mask0/i_mask1  cell select, 1 = apply op to that cell
//   o_gnt0/o_gnt1    requester owns the bank (APPLY + DONE cycles)
//   o_done           one-cycle completion pulse, q already updated
//   o_q              cell outputs
//   o_qb             ~o_q
// ---------------------------------------------------------------------------
module jk_bank_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0,
    input  logic [1:0]       i_jk0,
    input  logic [WIDTH-1:0] i_mask0,
    input  logic             i_req1,
    input  logic [1:0]       i_jk1,
    input  logic [WIDTH-1:0] i_mask1,
    output logic             o_gnt0,
    output logic             o_gnt1,
    output logic             o_done,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_qb
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       r_jk;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_q;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_done;
`ifndef JK_BANK_FIXED_PRIO_EN
    logic             r_sel;   // requester currently being served
    logic             r_last;  // requester served last (1 = req1)
`endif

    logic             w_pick1;
    logic [WIDTH-1:0] w_q_next;

    // Winner selection; only meaningful when at least one request is high.
    always_comb begin
        w_pick1 = 1'b0;
`ifdef JK_BANK_FIXED_PRIO_EN
        w_pick1 = i_req1 && !i_req0;
`else
        // On a tie, req1 wins only if req0 was the one served last.
        w_pick1 = i_req1 && (!i_req0 || !r_last);
`endif
    end

    // Per-cell JK next state under the latched op and mask.
    always_comb begin
        w_q_next = r_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_mask[i]) begin
                case (r_jk)
                    2'b01:   w_q_next[i] = 1'b0;
                    2'b10:   w_q_next[i] = 1'b1;
                    2'b11:   w_q_next[i] = ~r_q[i];
                    default: w_q_next[i] = r_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_jk    <= 2'b00;
            r_mask  <= '0;
            r_q     <= '0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done  <= 1'b0;
`ifndef JK_BANK_FIXED_PRIO_EN
            r_sel   <= 1'b0;
            r_last  <= 1'b1;   // pretend req1 went last so req0 wins the first tie
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req0 || i_req1) begin
                        r_jk    <= w_pick1 ? i_jk1   : i_jk0;
                        r_mask  <= w_pick1 ? i_mask1 : i_mask0;
                        r_gnt0  <= !w_pick1;
                        r_gnt1  <= w_pick1;
`ifndef JK_BANK_FIXED_PRIO_EN
                        r_sel   <= w_pick1;
`endif
                        r_state <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    r_q     <= w_q_next;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_done  <= 1'b0;
`ifndef JK_BANK_FIXED_PRIO_EN
                    r_last  <= r_sel;
`endif
                    r_state <= ST_IDLE;
                end
                default: begin
                    // Unreachable encoding: release the bank and recover.
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_gnt0 = r_gnt0;
    assign o_gnt1 = r_gnt1;
    assign o_done = r_done;
    assign o_q    = r_q;
    assign o_qb   = ~r_q;

endmodule
